life_engine: RTL

//  Sequential, parametrised Game-of-Life core built on the combinational next-state rule.
//  - Holds a WIDTH x HEIGHT grid in registers and steps it one generation per clock for a

---
 rtl/life_engine.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/life_engine.sv
// life_engine: registered Game-of-Life grid that advances one generation per clock
// for a requested number of generations, with dead-edge or toroidal neighbourhoods.
// Optional feature macro: LIFE_ENGINE_EARLY_HALT_EN (a run ends early once the grid
// is still or extinct).
module life_engine #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [WIDTH*HEIGHT-1:0]   load_state,
  input  logic                      step_valid,
  output logic                      step_ready,
  input  logic [GEN_W-1:0]          step_count,
  input  logic                      wrap,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH*HEIGHT-1:0]   state,
  output logic [GEN_W-1:0]          gen_count,
  output logic                      stable,
  output logic                      extinct
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic {IDLE, RUN} fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [CELLS-1:0]   grid_q, grid_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [GEN_W-1:0]   remain_q, remain_d;
  logic               stable_q, stable_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [CELLS-1:0]   next_grid;
  logic               halt;

  // Cell (r,c) lives at bit CELLS-1-(r*WIDTH+c): row 0 is the MSB word.
  function automatic logic [IDX_W-1:0] cell_idx(input int unsigned r, input int unsigned c);
    return IDX_W'(CELLS - 1 - (r * WIDTH + c));
  endfunction

  // Neighbour offsets are biased by +1 so the scan stays unsigned; indices 0 and
  // HEIGHT+1 / WIDTH+1 are the off-grid positions that wrap or read as dead.
  function automatic logic [CELLS-1:0] life_next(input logic [CELLS-1:0] g, input logic wr);
    logic [CELLS-1:0] n;
    logic [3:0]       cnt;
    int unsigned      rr, cc;
    n = '0;
    for (int unsigned r = 0; r < HEIGHT; r++) begin
      for (int unsigned c = 0; c < WIDTH; c++) begin
        cnt = '0;
        for (int unsigned dr = 0; dr < 3; dr++) begin
          for (int unsigned dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              rr = r + dr;
              cc = c + dc;
              if (wr || (rr >= 1 && rr <= HEIGHT && cc >= 1 && cc <= WIDTH))
                cnt = cnt + {3'b000, g[cell_idx((rr + HEIGHT - 1) % HEIGHT,
                                                (cc + WIDTH - 1) % WIDTH)]};
            end
          end
        end
        n[cell_idx(r, c)] = (cnt == 4'd3) || (g[cell_idx(r, c)] && cnt == 4'd2);
      end
    end
    return n;
  endfunction

  // Next generation of the current grid using the edge mode captured at step accept.
  always_comb begin
    next_grid = life_next(grid_q, wrap_q);
`ifdef LIFE_ENGINE_EARLY_HALT_EN
    halt = (remain_q == GEN_W'(1)) || (next_grid == grid_q) || (next_grid == '0);
`else
    halt = (remain_q == GEN_W'(1));
`endif
  end

  // Handshake, run control and grid update.
  always_comb begin
    fsm_d    = fsm_q;
    grid_d   = grid_q;
    gen_d    = gen_q;
    remain_d = remain_q;
    stable_d = stable_q;
    done_d   = 1'b0;
    wrap_d   = wrap_q;
    case (fsm_q)
      IDLE: begin
        if (load_valid) begin
          grid_d   = load_state;
          gen_d    = '0;
          stable_d = 1'b0;
        end else if (step_valid) begin
          wrap_d = wrap;
          if (step_count == '0) begin
            done_d = 1'b1;
          end else begin
            fsm_d    = RUN;
            remain_d = step_count;
          end
        end
      end
      RUN: begin
        grid_d   = next_grid;
        gen_d    = gen_q + GEN_W'(1);
        stable_d = (next_grid == grid_q);
        remain_d = remain_q - GEN_W'(1);
        if (halt) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      grid_q   <= '0;
      gen_q    <= '0;
      remain_q <= '0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      grid_q   <= grid_d;
      gen_q    <= gen_d;
      remain_q <= remain_d;
      stable_q <= stable_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign load_ready = (fsm_q == IDLE);
  assign step_ready = (fsm_q == IDLE) && !load_valid;
  assign busy       = (fsm_q == RUN);
  assign done       = done_q;
  assign state      = grid_q;
  assign gen_count  = gen_q;
  assign stable     = stable_q;
  assign extinct    = (grid_q == '0);

endmodule
